aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES-128 round sequencer. Owns the 128-bit state register and accepts one plaintext per handshake.
//  Applies the initial AddRoundKey, then drives NR passes through the external registered round datapath
//  (SubBytes -> ShiftRows -> MixColumns). After each pass it XORs in the next round key, then presents
//  the ciphertext on a valid/ready output. Sits between the host stream interface and the round datapath/key-schedule ROM.
// PARAMETERS
//  NR         10  number of rounds (AES-128); rounds 1..NR, round NR flagged as final
//  STAGE_LAT  3   clock edges from dp_data change to valid dp_in (registered datapath stages), >=1
//  RW         4   width of round index, must hold NR
// PORTS
//  clk        in   1    single clock, all state on posedge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    plaintext offered
//  in_ready   out  1    controller idle, can accept
//  in_data    in   128  plaintext block, sampled on accept edge
//  rk_idx     out  RW   round-key index to key schedule (combinational from round)
//  rk         in   128  round key for rk_idx, valid same cycle
//  dp_data    out  128  state presented to round datapath (= state register)
//  dp_last    out  1    1 during final round: datapath bypasses MixColumns
//  dp_in      in   128  round datapath result
//  out_valid  out  1    ciphertext available
//  out_ready  in   1    consumer accepts ciphertext
//  out_data   out  128  ciphertext, stable while out_valid
//  busy       out  1    1 in RUN or DONE
// BEHAVIOUR
//  Reset: FSM=IDLE, state reg=0, round=0, cnt=0, out_valid=0, out_data=0. Consequently in_ready=1, busy=0, dp_last=0.
//  FSM states IDLE, RUN, DONE. in_ready = (FSM==IDLE). busy = !IDLE.
//  rk_idx = round in RUN, 0 in IDLE/DONE. dp_last = (FSM==RUN && round==NR).
//  IDLE: on in_valid&&in_ready edge: state <= in_data ^ rk (rk_idx=0), round <= 1, cnt <= STAGE_LAT, -> RUN.
//  RUN: dp_data held constant. If cnt!=0: cnt-- each edge. If cnt==0 (capture edge): state <= dp_in ^ rk.
//   If round==NR: out_data <= dp_in ^ rk, out_valid <= 1, -> DONE. Otherwise round++, cnt <= STAGE_LAT.
//  Round timing: each round takes STAGE_LAT+1 cycles.
//  Latency: accept edge A -> out_valid high after edge A+NR*(STAGE_LAT+1) (40 cycles at defaults).
//  DONE: out_data/out_valid held until out_valid&&out_ready edge; then out_valid <= 0, round <= 0, -> IDLE.
//   No new accept occurs in that same edge. Issue rate: one block per NR*(STAGE_LAT+1)+2 cycles minimum.
//  Busy input: in_valid while busy is ignored; no buffering and no error.
//  Output backpressure: out_ready low holds DONE indefinitely; out_data must not change.
//  Reset mid-operation: immediate IDLE; the in-flight block is discarded; no out_valid pulse.
//  Round arithmetic: round wraps never (bounded by NR). cnt width = clog2(STAGE_LAT+1).
//  Unused inputs: dp_in is ignored except at capture edges; rk is ignored outside accept/capture edges.
// CONFIGURATION
//  AES_ABORT_EN defined: adds input port abort (1 bit, after busy).
//   abort high at an edge in RUN or DONE -> IDLE, out_valid <= 0, round <= 0; state reg is not cleared.
//   abort has priority over capture and over the out handshake in the same edge.
//   In IDLE, abort high blocks accept: in_ready=0 while abort=1.
//  AES_ABORT_EN undefined: no abort port. A block, once accepted, always completes unless rst is asserted.
// TESTING
//  Bench provides behavioural registered round datapath (latency STAGE_LAT) and FIPS-197 key-schedule ROM.
//  1 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff
//     -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 40 cycles after accept.
//  2 dp_last check: dp_last high only during the 4 cycles of round 10.
//     rk_idx sequence 0,1..10; each of 1..9 held 4 cycles.
//  3 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0.
//     in_valid pulses during this window are ignored. out_ready=1 -> IDLE next cycle.
//  4 Back-to-back: in_valid held high, out_ready=1, two blocks -> second accept 42 cycles after first.
//     Both ciphertexts are correct.
//  5 Reset mid-op: assert rst at round 5 -> outputs at reset values asynchronously; no out_valid.
//     Next block after release is correct.
//  6 (AES_ABORT_EN) abort at round 3 -> IDLE next edge, no out_valid.
//     abort coincident with out handshake -> IDLE, out_valid 0. Both builds rerun tests 1-5.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 round sequencer around an external registered round datapath.
// Defining AES_ABORT_EN adds an abort input that returns the controller to IDLE.
module aes_round_ctrl #(
    parameter int NR        = 10,
    parameter int STAGE_LAT = 3,
    parameter int RW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rk,
    output logic [127:0]  dp_data,
    output logic          dp_last,
    input  logic [127:0]  dp_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
`ifdef AES_ABORT_EN
    ,
    input  logic          abort
`endif
);
    localparam int CW = (STAGE_LAT < 1) ? 1 : $clog2(STAGE_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          fsm_q;
    logic [127:0]  state_q, state_d, out_q;
    logic [RW-1:0] round_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic          abort_w;

`ifdef AES_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign in_ready  = fsm_q == IDLE && !abort_w;
    assign busy      = fsm_q != IDLE;
    assign rk_idx    = fsm_q == RUN ? round_q : '0;
    assign dp_last   = fsm_q == RUN && round_q == RW'(NR);
    assign dp_data   = state_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    // Same XOR serves the initial AddRoundKey and every round-end AddRoundKey.
    assign state_d   = (fsm_q == IDLE ? in_data : dp_in) ^ rk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            out_q       <= '0;
            round_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (abort_w && fsm_q != IDLE) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            round_q     <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid && in_ready) begin
                    state_q <= state_d;
                    round_q <= RW'(1);
                    cnt_q   <= CW'(STAGE_LAT);
                    fsm_q   <= RUN;
                end
                RUN: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    state_q <= state_d;
                    if (round_q == RW'(NR)) begin
                        out_q       <= state_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        round_q <= round_q + RW'(1);
                        cnt_q   <= CW'(STAGE_LAT);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    round_q     <= '0;
                    fsm_q       <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: bench with behavioural AES round datapath, key-schedule ROM and full-cipher reference.
// Abort scenarios are compiled in when AES_ABORT_EN is defined.
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam int SL = 3;

    logic         clk = 0, rst = 0, in_valid = 0, out_ready = 0, abort = 0;
    logic [127:0] in_data = '0, rk, dp_in, dp_data, out_data;
    logic [3:0]   rk_idx;
    logic         in_ready, dp_last, out_valid, busy;
    int           cyc = 0, checks = 0, failures = 0;
    logic [7:0]   sbox [256];
    logic [127:0] rks [11];
    logic [127:0] pipe [SL];

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk(rk), .dp_data(dp_data), .dp_last(dp_last), .dp_in(dp_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef AES_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last)
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rks[0];
        for (int r = 1; r <= NR; r++) s = round_fn(s, r == NR) ^ rks[r];
        return s;
    endfunction

    // Registered round datapath: result appears SL edges after dp_data changes.
    always @(posedge clk) begin
        pipe[0] <= round_fn(dp_data, dp_last);
        for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_in = pipe[SL-1];
    always_comb rk = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (a != 0 && gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            x = inv;
            for (int k = 1; k < 5; k++) x = x ^ ((inv << k) | (inv >> (8 - k)));
            sbox[a] = x ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_block(input logic [127:0] pt, output int acc);
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk);
            in_data = pt;
            in_valid = 1;
            if (in_ready) acc = cyc + 1;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_out(output int e, output bit ok);
        ok = 0;
        e = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; e = cyc; end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (dp_data !== 128'h0) begin failures++; $display("FAIL rst_dp_data got=%h exp=0", dp_data); end
        checks++; if (dp_last !== 1'b0 || rk_idx !== 4'd0) begin failures++; $display("FAIL rst_round got=%b/%0d exp=0/0", dp_last, rk_idx); end
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%b/%b exp=1/0", in_ready, busy); end
    endtask

    task automatic test_fips();
        int a, e;
        bit ok;
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        send_block(128'h00112233445566778899aabbccddeeff, a);
        wait_out(e, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fips_timeout got=%b exp=1", ok); end
        checks++; if (e - a !== 40) begin failures++; $display("FAIL fips_latency got=%0d exp=40", e - a); end
        checks++; if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin failures++; $display("FAIL fips_ct got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
        checks++; if (out_data !== aes_enc(128'h00112233445566778899aabbccddeeff)) begin failures++; $display("FAIL fips_model got=%h exp=%h", out_data, aes_enc(128'h00112233445566778899aabbccddeeff)); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL fips_release got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_round_seq();
        int a, nlast, badlast;
        int hist [16];
        logic [127:0] pt;
        for (int it = 0; it < 2; it++) begin
            set_key(rnd128());
            pt = rnd128();
            foreach (hist[i]) hist[i] = 0;
            nlast = 0;
            badlast = 0;
            send_block(pt, a);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (out_valid) break;
                hist[rk_idx]++;
                if (dp_last) begin nlast++; if (rk_idx != 4'd10) badlast++; end
            end
            for (int r = 1; r <= NR; r++) begin
                checks++; if (hist[r] !== 4) begin failures++; $display("FAIL seq_rk_idx%0d got=%0d exp=4", r, hist[r]); end
            end
            checks++; if (hist[0] !== 0) begin failures++; $display("FAIL seq_rk_idx0_in_run got=%0d exp=0", hist[0]); end
            checks++; if (nlast !== 4 || badlast !== 0) begin failures++; $display("FAIL seq_dp_last got=%0d/%0d exp=4/0", nlast, badlast); end
            checks++; if (out_data !== aes_enc(pt)) begin failures++; $display("FAIL seq_ct got=%h exp=%h", out_data, aes_enc(pt)); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int a, e;
        bit ok, stable = 1, rdy_bad = 0;
        logic [127:0] pt, exp;
        set_key(rnd128());
        pt = rnd128();
        exp = aes_enc(pt);
        send_block(pt, a);
        wait_out(e, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", ok); end
        for (int i = 0; i < 20; i++) begin
            if (out_data !== exp || out_valid !== 1'b1) stable = 0;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1;
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data = rnd128();
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_out_stable got=%b exp=1", stable); end
        checks++; if (rdy_bad !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", rdy_bad); end
        checks++; if (out_data !== exp) begin failures++; $display("FAIL bp_ct got=%h exp=%h", out_data, exp); end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b%b%b exp=100", in_ready, out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        logic [127:0] ct [2];
        logic [127:0] p1, p2;
        int n_acc = 0, n_out = 0;
        bit just_acc = 0;
        set_key(rnd128());
        p1 = rnd128();
        p2 = rnd128();
        acc[0] = 0; acc[1] = 0; ct[0] = '0; ct[1] = '0;
        @(negedge clk);
        in_data = p1;
        in_valid = 1;
        out_ready = 1;
        for (int i = 0; i < 150 && n_out < 2; i++) begin
            if (just_acc) begin in_data = p2; just_acc = 0; if (n_acc == 2) in_valid = 0; end
            if (in_valid && in_ready && n_acc < 2) begin acc[n_acc] = cyc + 1; n_acc++; just_acc = 1; end
            if (out_valid && out_ready && n_out < 2) begin ct[n_out] = out_data; n_out++; end
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 0;
        checks++; if (n_out !== 2) begin failures++; $display("FAIL b2b_outputs got=%0d exp=2", n_out); end
        checks++; if (acc[1] - acc[0] !== 42) begin failures++; $display("FAIL b2b_spacing got=%0d exp=42", acc[1] - acc[0]); end
        checks++; if (ct[0] !== aes_enc(p1)) begin failures++; $display("FAIL b2b_ct0 got=%h exp=%h", ct[0], aes_enc(p1)); end
        checks++; if (ct[1] !== aes_enc(p2)) begin failures++; $display("FAIL b2b_ct1 got=%h exp=%h", ct[1], aes_enc(p2)); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int a, e;
        bit ok, found = 0, seen = 0;
        logic [127:0] pt;
        set_key(rnd128());
        send_block(rnd128(), a);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rk_idx == 4'd5) found = 1;
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL mid_reach_round5 got=%b exp=1", found); end
        #2 rst = 1;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl got=%b%b%b exp=100", in_ready, busy, out_valid); end
        checks++; if (out_data !== 128'h0 || dp_data !== 128'h0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", out_data, dp_data); end
        checks++; if (rk_idx !== 4'd0 || dp_last !== 1'b0) begin failures++; $display("FAIL mid_rst_round got=%0d/%b exp=0/0", rk_idx, dp_last); end
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_out_valid got=%b exp=0", seen); end
        pt = rnd128();
        send_block(pt, a);
        wait_out(e, ok);
        checks++; if (ok !== 1'b1 || out_data !== aes_enc(pt)) begin failures++; $display("FAIL mid_next_ct got=%h exp=%h", out_data, aes_enc(pt)); end
        release_out();
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        int a, e;
        bit ok, found = 0, seen = 0;
        logic [127:0] pt;
        set_key(rnd128());
        send_block(rnd128(), a);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rk_idx == 4'd3) found = 1;
        end
        abort = 1;
        @(negedge clk);
        checks++; if (found !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_round3 got=%b%b%b exp=100", found, busy, out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_blocks_accept got=%b exp=0", in_ready); end
        abort = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_release_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_out_valid got=%b exp=0", seen); end
        send_block(rnd128(), a);
        wait_out(e, ok);
        @(negedge clk);
        out_ready = 1;
        abort = 1;
        @(negedge clk);
        out_ready = 0;
        abort = 0;
        checks++; if (ok !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_handshake got=%b%b%b exp=100", ok, out_valid, busy); end
        pt = rnd128();
        send_block(pt, a);
        wait_out(e, ok);
        checks++; if (ok !== 1'b1 || out_data !== aes_enc(pt)) begin failures++; $display("FAIL abort_next_ct got=%h exp=%h", out_data, aes_enc(pt)); end
        release_out();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        #1 rst = 1;
        test_reset();
        test_fips();
        test_round_seq();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
